// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared state encoding and port constants for the memory port arbiter
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    I_BUSY  = 2'b01,
    D_BUSY  = 2'b10,
    RELEASE = 2'b11
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam logic [3:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/arb_timeout_counter.sv
// rtl/arb_timeout_counter.sv - bus timeout counter with clear/enable, flags expiry at TIMEOUT-1
module arb_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch (I) and load/store (D)
// D has priority; an I starvation guard and a bus timeout with error return are included.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic                grant_port;
  logic                in_busy;
  logic                tmo_expired;

  assign in_busy = (state == I_BUSY) || (state == D_BUSY);

  // D wins a tie unless I has already been passed over MAX_D_STREAK times in a row.
  always_comb begin
    grant_port = PORT_I;
    if (d_req && !(i_req && streak == STREAK_MAX)) grant_port = PORT_D;
  end

  arb_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_busy),
    .enable (in_busy && !mem_ack),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= '0;
      i_ack     <= 1'b0;
      i_rdata   <= '0;
      i_err     <= 1'b0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= BE_NONE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      i_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            busy    <= 1'b1;
            mem_req <= 1'b1;
            if (grant_port == PORT_D) begin
              state     <= D_BUSY;
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_be    <= d_we ? d_be : BE_NONE;
              mem_wdata <= d_wdata;
              if (!i_req)                 streak <= '0;
              else if (streak != STREAK_MAX) streak <= streak + 1'b1;
            end else begin
              state     <= I_BUSY;
              mem_addr  <= i_addr;
              mem_we    <= 1'b0;
              mem_be    <= BE_NONE;
              mem_wdata <= '0;
              streak    <= '0;
            end
          end
        end
        I_BUSY, D_BUSY: begin
          // A mem_ack in the expiry cycle still counts as a normal completion.
          if (mem_ack || tmo_expired) begin
            mem_req <= 1'b0;
            state   <= RELEASE;
            if (state == I_BUSY) begin
              i_ack   <= 1'b1;
              i_err   <= !mem_ack;
              i_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              d_ack   <= 1'b1;
              d_err   <= !mem_ack;
              d_rdata <= mem_ack ? mem_rdata : '0;
            end
          end
        end
        RELEASE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  int          checks = 0;
  int          errors = 0;

  int          lat = 1;
  logic [31:0] rdata_val = '0;
  logic        inject = 1'b0;
  int          mem_cyc = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: acks on the lat-th edge after mem_req rises (lat=0 never acks).
  always @(posedge clk) begin
    #2;
    if (mem_req) mem_cyc = mem_cyc + 1;
    else         mem_cyc = 0;
    mem_ack   = (mem_req && lat != 0 && mem_cyc == lat) || inject;
    mem_rdata = rdata_val;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] mrdata;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[7];

  // Starts at a negedge with the arbiter idle; returns at a negedge with it idle again.
  task automatic run_vec(input vec_t v, input string tag);
    int   cyc;
    logic other_seen;
    lat       = v.lat;
    rdata_val = v.mrdata;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    cyc = 0;
    other_seen = 1'b0;
    for (int k = 1; k <= 40 && cyc == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({tag, "_mem_req"}, 64'(mem_req), 64'(1'b1));
        check({tag, "_mem_we"}, 64'(mem_we), 64'(v.exp_we));
        check({tag, "_mem_be"}, 64'(mem_be), 64'(v.exp_be));
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'(v.addr));
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(v.exp_wdata));
      end
      if (v.lat == 0 && k == TIMEOUT) inject = 1'b1;
      other_seen = other_seen | (v.is_d ? i_ack : d_ack);
      if (v.is_d ? d_ack : i_ack) begin
        cyc = k;
        inject = 1'b0;
        check({tag, "_rdata"}, 64'(v.is_d ? d_rdata : i_rdata), 64'(v.exp_rdata));
        check({tag, "_err"}, 64'(v.is_d ? d_err : i_err), 64'(v.exp_err));
        check({tag, "_mem_req_drop"}, 64'(mem_req), 64'(1'b0));
        if (v.is_d) d_req = 1'b0;
        else        i_req = 1'b0;
      end
    end
    inject = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'(v.exp_cyc));
    check({tag, "_other_ack"}, 64'(other_seen), 64'(1'b0));
    @(negedge clk);
    check({tag, "_post_ack_err"}, 64'({i_ack, d_ack, i_err, d_err}), 64'(0));
    check({tag, "_post_busy"}, 64'({busy, mem_req}), 64'(0));
  endtask

  initial begin
    logic [5:0] seq;
    int         n;
    int         i_cyc;
    int         d_cyc;
    logic       both_seen;
    logic       ack_seen;
    vec_t       v;

    vecs[0] = '{1'b0, 1'b0, 4'h0,    32'h0000_0010, 32'h0,         1, 32'h0051_3093,
                1'b0, 4'h0,    32'h0,         32'h0051_3093, 1'b0, 2};
    vecs[1] = '{1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'h0,
                1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h0,         1'b0, 2};
    vecs[2] = '{1'b1, 1'b0, 4'b1111, 32'h0000_0100, 32'h0,         2, 32'h0000_BEEF,
                1'b0, 4'h0,    32'h0,         32'h0000_BEEF, 1'b0, 3};
    vecs[3] = '{1'b0, 1'b0, 4'h0,    32'h2000_0004, 32'h0,         3, 32'hCAFE_F00D,
                1'b0, 4'h0,    32'h0,         32'hCAFE_F00D, 1'b0, 4};
    vecs[4] = '{1'b1, 1'b0, 4'h0,    32'h0000_0300, 32'h0,         0, 32'h7777_7777,
                1'b0, 4'h0,    32'h0,         32'h0,         1'b1, TIMEOUT + 1};
    vecs[5] = '{1'b1, 1'b0, 4'h0,    32'h0000_0304, 32'h0,         1, 32'hA5A5_5A5A,
                1'b0, 4'h0,    32'h0,         32'hA5A5_5A5A, 1'b0, 2};
    vecs[6] = '{1'b1, 1'b1, 4'b1100, 32'h0000_0308, 32'h0F0F_0F0F, 4, 32'h0,
                1'b1, 4'b1100, 32'h0F0F_0F0F, 32'h0,         1'b0, 5};

    @(negedge clk);
    @(negedge clk);
    check("rst_ctrl", 64'({i_ack, i_err, d_ack, d_err, mem_req, mem_we, mem_be, busy}), 64'(0));
    check("rst_rdata", 64'({i_rdata, d_rdata}), 64'(0));
    check("rst_mem", 64'({mem_addr, mem_wdata}), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    check("i_rdata_hold", 64'(i_rdata), 64'(32'hCAFE_F00D));

    // Simultaneous requests: D first, I after RELEASE, never both acks together.
    lat = 1; rdata_val = 32'h0BAD_C0DE;
    d_we = 1'b0; d_addr = 32'h80; i_addr = 32'h40;
    i_req = 1'b1; d_req = 1'b1;
    i_cyc = 0; d_cyc = 0; both_seen = 1'b0;
    for (int k = 1; k <= 30 && (i_cyc == 0 || d_cyc == 0); k++) begin
      @(negedge clk);
      both_seen = both_seen | (i_ack & d_ack);
      if (d_ack) begin d_cyc = k; d_req = 1'b0; end
      if (i_ack) begin i_cyc = k; i_req = 1'b0; end
    end
    check("simul_d_cyc", 64'(d_cyc), 64'(2));
    check("simul_i_cyc", 64'(i_cyc), 64'(5));
    check("simul_both", 64'(both_seen), 64'(0));
    check("simul_rdata", 64'({i_rdata, d_rdata}), {32'h0BAD_C0DE, 32'h0BAD_C0DE});
    repeat (2) @(negedge clk);

    // Starvation guard: D held high continuously with I waiting.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    d_addr = 32'h400; i_addr = 32'h44;
    d_req = 1'b1; i_req = 1'b1;
    seq = '0; n = 0; both_seen = 1'b0;
    for (int k = 1; k <= 80 && n < 6; k++) begin
      @(negedge clk);
      both_seen = both_seen | (i_ack & d_ack);
      if (d_ack) begin seq[n] = 1'b1; n++; end
      else if (i_ack) begin seq[n] = 1'b0; n++; i_req = 1'b0; end
    end
    d_req = 1'b0;
    check("starve_count", 64'(n), 64'(6));
    check("starve_seq", 64'(seq), 64'(6'b101111));
    check("starve_both", 64'(both_seen), 64'(0));
    repeat (3) @(negedge clk);

    // Reset in the middle of a D transfer.
    lat = 0;
    d_we = 1'b0; d_addr = 32'h500; d_req = 1'b1;
    repeat (3) @(negedge clk);
    check("rmid_busy_before", 64'({busy, mem_req}), 64'(2'b11));
    rst = 1'b1;
    #1;
    check("rmid_async_drop", 64'({busy, mem_req}), 64'(0));
    d_req = 1'b0;
    ack_seen = 1'b0;
    repeat (3) begin @(negedge clk); ack_seen = ack_seen | d_ack | i_ack; end
    check("rmid_rdata_clr", 64'(d_rdata), 64'(0));
    rst = 1'b0;
    repeat (20) begin @(negedge clk); ack_seen = ack_seen | d_ack | i_ack; end
    check("rmid_no_ack", 64'(ack_seen), 64'(0));
    v = '{1'b0, 1'b0, 4'h0, 32'h0000_0600, 32'h0, 2, 32'h1357_9BDF,
          1'b0, 4'h0, 32'h0, 32'h1357_9BDF, 1'b0, 3};
    run_vec(v, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between two requesters: instruction fetch (port 0, I) and load/store (port 1, D).
- Sits between the fetch/memory stages of the multi-cycle CPU and the memory macro.
- Provides a req/ack handshake per port, variable memory latency, fixed D-over-I priority with an I starvation guard, and a bus timeout that returns an error.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- MAX_D_STREAK, 4, consecutive D grants allowed while I is waiting; the next grant then goes to I.
- TIMEOUT, 16, cycles to wait for mem_ack before aborting (must be ≥2).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-high.
- i_req  in  1  fetch request; held high until i_ack.
- i_addr  in  ADDR_W  fetch address; stable while i_req is high.
- i_ack  out  1  one-cycle pulse: i_rdata/i_err valid.
- i_rdata  out  DATA_W  fetched instruction word.
- i_err  out  1  with i_ack: transfer timed out.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1=store, 0=load.
- d_be  in  4  byte enables for stores.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  DATA_W  load data.
- d_err  out  1  with d_ack: timeout.
- mem_req  out  1  memory strobe; high for the whole transfer.
- mem_we  out  1  write enable to memory.
- mem_be  out  4  byte enables (4'b0000 for reads).
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_ack  in  1  memory completion (1-cycle pulse, ≥1 cycle after mem_req rises).
- mem_rdata  in  DATA_W  valid when mem_ack is high.
- busy  out  1  high in any non-IDLE state.

Behaviour:
- Reset: all outputs 0, state IDLE, streak counter 0, timeout counter 0. Reset asserted mid-transfer aborts it immediately: no ack is ever issued for that transfer, and mem_req drops asynchronously.
- States:
  - IDLE: choose a winner, register addr/we/be/wdata, go to I_BUSY or D_BUSY, and raise mem_req in the next cycle.
  - I_BUSY / D_BUSY: mem_req=1 with registered outputs held constant. On mem_ack, pulse the owner's ack for 1 cycle and capture rdata into the owner's rdata register. Go to RELEASE.
  - RELEASE: 1 cycle, mem_req=0, then IDLE. There is no back-to-back issue, so the requester sees its ack before the arbiter re-samples req. A requester must deassert req in the cycle after ack.
- Latency: req seen in IDLE at edge N → mem_req high from N+1. mem_ack at edge M → ack high during M+1. Minimum request-to-ack is 2 cycles for a 1-cycle memory.
- Arbitration (evaluated in IDLE only):
  - Only one requesting: grant it.
  - Both requesting: grant D unless streak == MAX_D_STREAK, in which case grant I.
  - Streak: increments on each D grant while i_req is high; clears on any I grant, or on a D grant with i_req low. It saturates at MAX_D_STREAK.
- Timeout: counter clears on entry to a BUSY state and increments each BUSY cycle without mem_ack. When it reaches TIMEOUT-1 without ack: drop mem_req, pulse the owner's ack with err=1 and rdata=0, then RELEASE. A mem_ack arriving in that same cycle wins: normal completion, err=0. A late mem_ack seen in RELEASE or IDLE is ignored.
- Registered outputs: rdata holds its last value until the next ack for that port. The err flag is only meaningful when ack is high and is 0 otherwise.
- Reads drive mem_be=0 and mem_we=0. I transfers are always reads.

Decomposition:
- Shared package cpu_mem_pkg:
  - state encoding (IDLE=2'b00, I_BUSY=2'b01, D_BUSY=2'b10, RELEASE=2'b11);
  - port id constants (PORT_I=0, PORT_D=1);
  - the BE_NONE constant.
- One natural sub-module, arb_timeout_counter: clear/enable/expired, parameterised by TIMEOUT. It is reused later for a peripheral bus bridge.
- The FSM, arbitration and streak logic stay in the top module.

Test Plan:
- Single fetch: i_req=1, i_addr=0x0000_0010, memory acks 1 cycle after mem_req with 0x0051_3093 → i_ack 2 cycles after i_req, i_rdata=0x0051_3093, i_err=0, mem_be=0.
- Store then load: d_we=1, d_be=4'b0011, d_addr=0x100, d_wdata=0xDEAD_BEEF → mem_we=1, mem_be=4'b0011, d_ack. A following load from 0x100 with mem_rdata=0x0000_BEEF gives d_rdata=0x0000_BEEF.
- Simultaneous: i_req and d_req both rise in the same cycle → D granted first. I is granted in the IDLE after RELEASE. Acks are never simultaneous.
- Starvation: d_req held high continuously (re-asserted after each ack) with i_req high, MAX_D_STREAK=4 → exactly 4 D grants, then 1 I grant, then D resumes.
- Timeout: memory never acks, TIMEOUT=16 → d_ack with d_err=1 and d_rdata=0 exactly 16 cycles after mem_req rises. A mem_ack injected 1 cycle later is ignored, and the next request completes normally.
- Reset mid-transfer: rst pulsed while in D_BUSY → mem_req=0 immediately, no d_ack. After rst falls, a new i_req completes normally.
